// File: rtl/hz_pkg.sv
// hz_pkg: scoreboard entry type, bubble constant and readiness helper for hazard_scoreboard
package hz_pkg;
    localparam int REG_AW = 5;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              isLoad;
    } sb_entry_t;
    localparam sb_entry_t SB_BUBBLE = '0;
    // a tracked producer's result exists once it reaches idx (loads need LOAD_LAT extra stages past M)
    function automatic logic hz_ready(sb_entry_t entry, int idx, int loadLat);
        return entry.valid && (entry.rd != '0) && (entry.isLoad ? (idx >= 1 + loadLat) : (idx >= 1));
    endfunction
endpackage

// File: rtl/hz_youngest_match.sv
// hz_youngest_match: priority encoder returning the youngest scoreboard entry writing src
module hz_youngest_match
    import hz_pkg::*;
#(
    parameter int N        = 2,
    parameter int BASE     = 1,
    parameter int SHIFT    = 0,
    parameter int LOAD_LAT = 1,
    parameter int IW       = 2
) (
    input  sb_entry_t [N-1:0]    entries,
    input  logic [REG_AW-1:0]    src,
    output logic                 hit,
    output logic [IW-1:0]        idx,
    output logic                 ready
);
    // scan oldest to youngest so the youngest match wins; readiness judged at index+SHIFT
    always_comb begin
        hit = 1'b0;
        idx = '0;
        ready = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (entries[i].valid && entries[i].rd == src && src != '0) begin
                hit = 1'b1;
                idx = IW'(i + BASE);
                ready = hz_ready(entries[i], i + BASE + SHIFT, LOAD_LAT);
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E..WB destination scoreboard with youngest-producer forwarding and load-use stall; HZ_STATS_EN adds stall/flush counters
module hazard_scoreboard
    import hz_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    localparam int SW      = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       d_valid,
    input  logic [4:0]                 d_rs1,
    input  logic [4:0]                 d_rs2,
    input  logic [4:0]                 d_rd,
    input  logic                       d_regwrite,
    input  logic                       d_is_load,
    input  logic [4:0]                 e_rs1,
    input  logic [4:0]                 e_rs2,
    input  logic [XLEN-1:0]            e_rf_a,
    input  logic [XLEN-1:0]            e_rf_b,
    input  logic                       flush_e,
    input  logic [DEPTH-1:0][XLEN-1:0] stage_data,
`ifdef HZ_STATS_EN
    output logic [31:0]                stall_cycles,
    output logic [31:0]                flush_count,
`endif
    output logic                       stall,
    output logic [SW-1:0]              fwd_sel_a,
    output logic [SW-1:0]              fwd_sel_b,
    output logic [XLEN-1:0]            op_a_e,
    output logic [XLEN-1:0]            op_b_e
);
    sb_entry_t [DEPTH-1:0] sb;
    sb_entry_t dEntry;
    logic eHitA, eRdyA, eHitB, eRdyB, dHitA, dRdyA, dHitB, dRdyB;
    logic [SW-1:0] eIdxA, eIdxB, unusedIdxA, unusedIdxB;
    assign dEntry = '{valid: d_valid && d_regwrite && d_rd != '0, rd: d_rd, isLoad: d_is_load};
    hz_youngest_match #(.N(DEPTH-1), .BASE(1), .SHIFT(0), .LOAD_LAT(LOAD_LAT), .IW(SW)) uEA (
        .entries(sb[DEPTH-1:1]), .src(e_rs1), .hit(eHitA), .idx(eIdxA), .ready(eRdyA));
    hz_youngest_match #(.N(DEPTH-1), .BASE(1), .SHIFT(0), .LOAD_LAT(LOAD_LAT), .IW(SW)) uEB (
        .entries(sb[DEPTH-1:1]), .src(e_rs2), .hit(eHitB), .idx(eIdxB), .ready(eRdyB));
    hz_youngest_match #(.N(DEPTH-1), .BASE(0), .SHIFT(1), .LOAD_LAT(LOAD_LAT), .IW(SW)) uDA (
        .entries(sb[DEPTH-2:0]), .src(d_rs1), .hit(dHitA), .idx(unusedIdxA), .ready(dRdyA));
    hz_youngest_match #(.N(DEPTH-1), .BASE(0), .SHIFT(1), .LOAD_LAT(LOAD_LAT), .IW(SW)) uDB (
        .entries(sb[DEPTH-2:0]), .src(d_rs2), .hit(dHitB), .idx(unusedIdxB), .ready(dRdyB));
    assign stall = d_valid && ((dHitA && !dRdyA) || (dHitB && !dRdyB));
    assign fwd_sel_a = (eHitA && eRdyA) ? eIdxA : '0;
    assign fwd_sel_b = (eHitB && eRdyB) ? eIdxB : '0;
    assign op_a_e = (fwd_sel_a == '0) ? e_rf_a : stage_data[fwd_sel_a];
    assign op_b_e = (fwd_sel_b == '0) ? e_rf_b : stage_data[fwd_sel_b];
    // advance every stage each edge; E takes a bubble on stall or flush
    always_ff @(posedge clk)
        if (rst) sb <= '0;
        else sb <= {sb[DEPTH-2:0], (stall || flush_e) ? SB_BUBBLE : dEntry};
`ifdef HZ_STATS_EN
    // saturating stall and flush event counters
    always_ff @(posedge clk)
        if (rst) begin
            stall_cycles <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (flush_e && flush_count != '1) flush_count <= flush_count + 32'd1;
        end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline scenarios with a queued-expectation monitor
module tb_hazard_scoreboard;
    typedef struct {
        int          inst;
        string       name;
        logic        stall;
        logic [1:0]  selA;
        logic [1:0]  selB;
        logic [31:0] opA;
        logic [31:0] opB;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic d_valid = 1'b0, d_regwrite = 1'b0, d_is_load = 1'b0, flush_e = 1'b0;
    logic [4:0] d_rs1 = '0, d_rs2 = '0, d_rd = '0, e_rs1 = '0, e_rs2 = '0;
    logic [31:0] rfA = 32'hAAAA_000A;
    logic [31:0] rfB = 32'hBBBB_000B;
    logic [2:0][31:0] sd3;
    logic [3:0][31:0] sd4;
    int act = 3;
    logic dv3, dv4;
    assign dv3 = d_valid && act == 3;
    assign dv4 = d_valid && act == 4;

    logic stall3, stall4;
    logic [1:0] selA3, selB3, selA4, selB4;
    logic [31:0] opA3, opB3, opA4, opB4;
`ifdef HZ_STATS_EN
    logic [31:0] stallCnt3, flushCnt3, stallCnt4, flushCnt4;
`endif

    hazard_scoreboard #(.XLEN(32), .DEPTH(3), .LOAD_LAT(1)) dut3 (
        .clk(clk), .rst(rst), .d_valid(dv3), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
        .d_regwrite(d_regwrite), .d_is_load(d_is_load), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .e_rf_a(rfA), .e_rf_b(rfB), .flush_e(flush_e), .stage_data(sd3),
`ifdef HZ_STATS_EN
        .stall_cycles(stallCnt3), .flush_count(flushCnt3),
`endif
        .stall(stall3), .fwd_sel_a(selA3), .fwd_sel_b(selB3), .op_a_e(opA3), .op_b_e(opB3));

    hazard_scoreboard #(.XLEN(32), .DEPTH(4), .LOAD_LAT(2)) dut4 (
        .clk(clk), .rst(rst), .d_valid(dv4), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
        .d_regwrite(d_regwrite), .d_is_load(d_is_load), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .e_rf_a(rfA), .e_rf_b(rfB), .flush_e(flush_e), .stage_data(sd4),
`ifdef HZ_STATS_EN
        .stall_cycles(stallCnt4), .flush_count(flushCnt4),
`endif
        .stall(stall4), .fwd_sel_a(selA4), .fwd_sel_b(selB4), .op_a_e(opA4), .op_b_e(opB4));

    exp_t q[$];
    exp_t cur;
    int errors = 0;
    int checks = 0;

    task automatic chk(string n, string f, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got=%h expected=%h", n, f, got, want);
        end
    endtask

    // monitor: pops one expectation per cycle it was issued for, compares mid-cycle
    always @(negedge clk) begin
        if ((dut3.eHitA && !dut3.eRdyA) || (dut3.eHitB && !dut3.eRdyB) ||
            (dut4.eHitA && !dut4.eRdyA) || (dut4.eHitB && !dut4.eRdyB)) begin
            errors++;
            $display("FAIL notready: E operand matched an unready producer got=1 expected=0");
        end
        if (q.size() != 0) begin
            cur = q.pop_front();
            chk(cur.name, "stall", cur.inst == 3 ? 32'(stall3) : 32'(stall4), 32'(cur.stall));
            chk(cur.name, "fwd_sel_a", cur.inst == 3 ? 32'(selA3) : 32'(selA4), 32'(cur.selA));
            chk(cur.name, "fwd_sel_b", cur.inst == 3 ? 32'(selB3) : 32'(selB4), 32'(cur.selB));
            chk(cur.name, "op_a_e", cur.inst == 3 ? opA3 : opA4, cur.opA);
            chk(cur.name, "op_b_e", cur.inst == 3 ? opB3 : opB4, cur.opB);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setD(logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd, logic rw, logic ld);
        d_valid = v; d_rs1 = r1; d_rs2 = r2; d_rd = rd; d_regwrite = rw; d_is_load = ld;
    endtask

    task automatic setE(logic [4:0] r1, logic [4:0] r2);
        e_rs1 = r1; e_rs2 = r2;
    endtask

    task automatic idle;
        setD(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        setE(5'd0, 5'd0);
        flush_e = 1'b0;
    endtask

    task automatic push(int inst, string n, logic s, logic [1:0] sa, logic [1:0] sb);
        exp_t e;
        e.inst = inst; e.name = n; e.stall = s; e.selA = sa; e.selB = sb;
        e.opA = (sa == 2'd0) ? rfA : (inst == 3 ? sd3[sa] : sd4[sa]);
        e.opB = (sb == 2'd0) ? rfB : (inst == 3 ? sd3[sb] : sd4[sb]);
        q.push_back(e);
    endtask

    task automatic doReset;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        sd3 = {32'hC3C3_0002, 32'hC3C3_0001, 32'hC3C3_0000};
        sd4 = {32'hD4D4_0003, 32'hD4D4_0002, 32'hD4D4_0001, 32'hD4D4_0000};
        act = 3;
        doReset();
        setE(5'd5, 5'd6); push(3, "reset", 1'b0, 2'd0, 2'd0); tick();
        // add x5 ; add x6,x5,x3
        idle(); setD(1, 1, 2, 5, 1, 0); push(3, "s1c1", 1'b0, 2'd0, 2'd0); tick();
        setD(1, 5, 3, 6, 1, 0); setE(1, 2); push(3, "s1c2", 1'b0, 2'd0, 2'd0); tick();
        idle(); setE(5, 3); push(3, "s1c3", 1'b0, 2'd1, 2'd0); tick();
        // lw x5 ; add x6,x5,x5
        doReset();
        setD(1, 1, 0, 5, 1, 1); push(3, "s2c1", 1'b0, 2'd0, 2'd0); tick();
        setD(1, 5, 5, 6, 1, 0); setE(1, 0); push(3, "s2stall", 1'b1, 2'd0, 2'd0); tick();
        setE(0, 0); push(3, "s2c3", 1'b0, 2'd0, 2'd0); tick();
        idle(); setE(5, 5); push(3, "s2fwd", 1'b0, 2'd2, 2'd2); tick();
        // addi x0 ; add x6,x0,x0
        doReset();
        setD(1, 0, 0, 0, 1, 0); push(3, "s3c1", 1'b0, 2'd0, 2'd0); tick();
        setD(1, 0, 0, 6, 1, 0); setE(0, 0); push(3, "s3c2", 1'b0, 2'd0, 2'd0); tick();
        idle(); setE(0, 0); push(3, "s3x0", 1'b0, 2'd0, 2'd0); tick();
        // add x5(A) ; add x5(B) ; add x7,x5,x9
        doReset();
        setD(1, 1, 2, 5, 1, 0); push(3, "s4c1", 1'b0, 2'd0, 2'd0); tick();
        setD(1, 3, 4, 5, 1, 0); setE(1, 2); push(3, "s4c2", 1'b0, 2'd0, 2'd0); tick();
        setD(1, 5, 9, 7, 1, 0); setE(3, 4); push(3, "s4c3", 1'b0, 2'd0, 2'd0); tick();
        idle(); setE(5, 9); push(3, "s4young", 1'b0, 2'd1, 2'd0); tick();
        // flushed producer is never tracked
        doReset();
        setD(1, 1, 2, 5, 1, 0); flush_e = 1'b1; push(3, "flc1", 1'b0, 2'd0, 2'd0); tick();
        flush_e = 1'b0; setD(1, 5, 0, 6, 1, 0); setE(0, 0); push(3, "flc2", 1'b0, 2'd0, 2'd0); tick();
`ifdef HZ_STATS_EN
        chk("flstats", "flush_count", flushCnt3, 32'd1);
        chk("flstats", "stall_cycles", stallCnt3, 32'd0);
`endif
        idle(); setE(5, 0); push(3, "flc3", 1'b0, 2'd0, 2'd0); tick();
        // flush during a stall: single bubble, consumer still issues once
        doReset();
        setD(1, 1, 0, 5, 1, 1); push(3, "fsc1", 1'b0, 2'd0, 2'd0); tick();
        setD(1, 5, 0, 6, 1, 0); setE(1, 0); flush_e = 1'b1; push(3, "fsstall", 1'b1, 2'd0, 2'd0); tick();
        flush_e = 1'b0; setE(0, 0); push(3, "fsc3", 1'b0, 2'd0, 2'd0); tick();
        idle(); setE(5, 0); push(3, "fsfwd", 1'b0, 2'd2, 2'd0); tick();
        setE(6, 0); push(3, "fsc5", 1'b0, 2'd1, 2'd0); tick();
        // DEPTH=4, LOAD_LAT=2: lw x5 ; add x6,x5,x8
        act = 4;
        doReset();
        setD(1, 1, 0, 5, 1, 1); push(4, "s5c1", 1'b0, 2'd0, 2'd0); tick();
        setD(1, 5, 8, 6, 1, 0); setE(1, 0); push(4, "s5stall1", 1'b1, 2'd0, 2'd0); tick();
        setE(0, 0); push(4, "s5stall2", 1'b1, 2'd0, 2'd0); tick();
        push(4, "s5go", 1'b0, 2'd0, 2'd0); tick();
        idle(); setE(5, 8); push(4, "s5fwd", 1'b0, 2'd3, 2'd0); tick();
        // reset asserted during a load-use stall
        act = 3;
        doReset();
        setD(1, 1, 0, 5, 1, 1); push(3, "s6c1", 1'b0, 2'd0, 2'd0); tick();
        setD(1, 5, 5, 6, 1, 0); setE(1, 0); push(3, "s6stall", 1'b1, 2'd0, 2'd0); rst = 1'b1; tick();
        rst = 1'b0; setE(5, 5); push(3, "s6after", 1'b0, 2'd0, 2'd0);
`ifdef HZ_STATS_EN
        chk("s6stats", "stall_cycles", stallCnt3, 32'd0);
        chk("s6stats", "flush_count", flushCnt3, 32'd0);
`endif
        tick();
        idle();
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expectations got=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
